// File: rtl/dm_result_checker.sv
// Self-check block: snoops DM writes for the DONE byte, then scans the answer region through an
// arbitrated read port and compares every word against a golden word source.
module dm_result_checker #(
   parameter int unsigned       ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] ANSWER_START = 16'h9000,
   parameter int unsigned       NUM_WORDS    = 128,
   parameter logic [ADDR_W-1:0] DONE_ADDR    = 16'hFFFC,
   parameter logic [7:0]        DONE_VALUE   = 8'hFF,
   parameter logic [31:0]       CMP_MASK     = 32'hFFFFFFFF,
   parameter int unsigned       MAX_CYCLES   = 10000000,
   parameter int unsigned       CYC_W        = 32,
   parameter int unsigned       IDX_W        = (NUM_WORDS == 0) ? 1 : $clog2(NUM_WORDS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              chk_req,
   output logic [ADDR_W-1:0] chk_addr,
   input  logic              chk_gnt,
   input  logic [31:0]       chk_rdata,
   output logic [IDX_W-1:0]  gold_idx,
   input  logic [31:0]       gold_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [IDX_W-1:0]  err_cnt,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [31:0]       first_err_got,
   output logic [CYC_W-1:0]  cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_SCAN,
      S_DRAIN,
      S_FIN,
      S_TMO
   } state_e;

   localparam int               DONE_LANE = int'(DONE_ADDR[1:0]);
   localparam logic [IDX_W-1:0] LAST_IDX  = (NUM_WORDS == 0) ? '0 : IDX_W'(NUM_WORDS - 1);
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
   logic             cmp_vld_q, cmp_vld_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [IDX_W-1:0] err_q, err_d;
   logic [IDX_W-1:0] fidx_q, fidx_d;
   logic [31:0]      fgot_q, fgot_d;

   logic done_hit;
   logic arm;
   logic mismatch;
   logic unused_snoop;

   // Only the DONE lane and the word part of the address qualify a hit.
   assign done_hit = (state_q == S_ARMED) && dm_we[DONE_LANE] &&
                     (dm_addr[ADDR_W-1:2] == DONE_ADDR[ADDR_W-1:2]) &&
                     (dm_wdata[8*DONE_LANE +: 8] == DONE_VALUE);
   assign unused_snoop = ^{dm_addr[1:0], dm_we, dm_wdata};

   assign arm      = start && (state_q == S_IDLE || state_q == S_FIN || state_q == S_TMO);
   assign mismatch = |((chk_rdata ^ gold_rdata) & CMP_MASK);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_ARMED;
         S_ARMED: begin
            if (done_hit) begin
               state_d = (NUM_WORDS == 0) ? S_FIN : S_SCAN;
            end else if (cyc_q == CYC_LAST) begin
               state_d = S_TMO;
            end
         end
         S_SCAN:  if (chk_gnt && idx_q == LAST_IDX) state_d = S_DRAIN;
         S_DRAIN: state_d = S_FIN;
         S_FIN,
         S_TMO:   if (start) state_d = S_ARMED;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      pass     = 1'b0;
      timeout  = 1'b0;
      chk_req  = 1'b0;
      chk_addr = '0;
      gold_idx = '0;
      case (state_q)
         S_ARMED: busy = 1'b1;
         S_SCAN: begin
            busy     = 1'b1;
            chk_req  = 1'b1;
            chk_addr = ANSWER_START + (ADDR_W'(idx_q) << 2);
            gold_idx = idx_q;
         end
         S_DRAIN: busy = 1'b1;
         S_FIN: begin
            done = 1'b1;
            pass = (err_q == '0);
         end
         S_TMO: begin
            done    = 1'b1;
            timeout = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: read issue, one-cycle-delayed compare, result capture.
   always_comb begin
      idx_d     = idx_q;
      cmp_idx_d = cmp_idx_q;
      cmp_vld_d = 1'b0;
      cyc_d     = cyc_q;
      err_d     = err_q;
      fidx_d    = fidx_q;
      fgot_d    = fgot_q;

      if (arm) begin
         idx_d  = '0;
         cyc_d  = '0;
         err_d  = '0;
         fidx_d = '0;
         fgot_d = '0;
      end

      if (state_q == S_ARMED && !done_hit) begin
         cyc_d = cyc_q + CYC_W'(1);
      end

      if (state_q == S_SCAN && chk_gnt) begin
         idx_d     = idx_q + IDX_W'(1);
         cmp_idx_d = idx_q;
         cmp_vld_d = 1'b1;
      end

      if (cmp_vld_q && mismatch) begin
         err_d = err_q + IDX_W'(1);
         if (err_q == '0) begin
            fidx_d = cmp_idx_q;
            fgot_d = chk_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q     <= '0;
         cmp_idx_q <= '0;
         cmp_vld_q <= 1'b0;
         cyc_q     <= '0;
         err_q     <= '0;
         fidx_q    <= '0;
         fgot_q    <= '0;
      end else begin
         idx_q     <= idx_d;
         cmp_idx_q <= cmp_idx_d;
         cmp_vld_q <= cmp_vld_d;
         cyc_q     <= cyc_d;
         err_q     <= err_d;
         fidx_q    <= fidx_d;
         fgot_q    <= fgot_d;
      end
   end

   assign err_cnt       = err_q;
   assign first_err_idx = fidx_q;
   assign first_err_got = fgot_q;
   assign cycle_cnt     = cyc_q;

endmodule

// File: tb/tb_dm_result_checker.sv
// Bench for dm_result_checker: two instances (full mask / bit0 masked) share stimulus; a DM/golden
// responder answers reads, a monitor checks the read stream, and directed tests check results.
module tb_dm_result_checker;

   localparam int          NW    = 4;
   localparam int          IW    = 3;
   localparam logic [15:0] START = 16'h9000;
   localparam int          MAXC  = 100;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  dm_we;
   logic [15:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        gnt_pat;
   int          gnt_mode;

   logic          req_a, gnt_a, busy_a, done_a, pass_a, tmo_a;
   logic [15:0]   addr_a;
   logic [31:0]   rdata_a, grd_a, fgot_a, cyc_a;
   logic [IW-1:0] gidx_a, err_a, fidx_a;

   logic          req_b, gnt_b, busy_b, done_b, pass_b, tmo_b;
   logic [15:0]   addr_b;
   logic [31:0]   rdata_b, grd_b, fgot_b, cyc_b;
   logic [IW-1:0] gidx_b, err_b, fidx_b;

   logic [31:0] dm_mem   [NW];
   logic [31:0] gold_mem [NW];

   int n_cmp  = 0;
   int n_fail = 0;
   int g_cnt  = 0;

   assign gnt_a = req_a & gnt_pat;
   assign gnt_b = req_b & gnt_pat;

   dm_result_checker #(
      .ADDR_W(16), .ANSWER_START(START), .NUM_WORDS(NW), .DONE_ADDR(16'hFFFC),
      .DONE_VALUE(8'hFF), .CMP_MASK(32'hFFFFFFFF), .MAX_CYCLES(MAXC), .CYC_W(32)
   ) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .chk_req(req_a), .chk_addr(addr_a), .chk_gnt(gnt_a), .chk_rdata(rdata_a),
      .gold_idx(gidx_a), .gold_rdata(grd_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .timeout(tmo_a), .err_cnt(err_a), .first_err_idx(fidx_a), .first_err_got(fgot_a),
      .cycle_cnt(cyc_a)
   );

   dm_result_checker #(
      .ADDR_W(16), .ANSWER_START(START), .NUM_WORDS(NW), .DONE_ADDR(16'hFFFC),
      .DONE_VALUE(8'hFF), .CMP_MASK(32'hFFFFFFFE), .MAX_CYCLES(MAXC), .CYC_W(32)
   ) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .chk_req(req_b), .chk_addr(addr_b), .chk_gnt(gnt_b), .chk_rdata(rdata_b),
      .gold_idx(gidx_b), .gold_rdata(grd_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .timeout(tmo_b), .err_cnt(err_b), .first_err_idx(fidx_b), .first_err_got(fgot_b),
      .cycle_cnt(cyc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [15:0] a);
      logic [15:0] off;
      off = a - START;
      if (off[15:2] < 14'(NW)) return dm_mem[off[15:2]];
      return 32'hDEADBEEF;
   endfunction

   function automatic logic [31:0] gold_at(input logic [IW-1:0] g);
      if (int'(g) < NW) return gold_mem[g];
      return 32'hDEADBEEF;
   endfunction

   // Registered DM / golden responders: data one cycle after the grant / index.
   initial begin
      rdata_a = '0; rdata_b = '0; grd_a = '0; grd_b = '0;
   end
   always @(posedge clk) begin
      if (gnt_a) rdata_a <= word_at(addr_a);
      if (gnt_b) rdata_b <= word_at(addr_b);
      grd_a <= gold_at(gidx_a);
      grd_b <= gold_at(gidx_b);
   end

   // Grant pattern: always granted, or 1,0,0 repeating.
   initial begin
      int phase;
      phase   = 0;
      gnt_pat = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         phase   = (phase + 1) % 3;
         gnt_pat = (gnt_mode == 0) || (phase == 0);
      end
   end

   // Read-stream monitor: k-th request must address word k, and no more than NW words per scan.
   always @(negedge clk) begin
      if (req_a === 1'b1) begin
         check("req_bound", 64'(g_cnt < NW), 64'd1);
         check("chk_addr", 64'(addr_a), 64'(START + 16'(4 * g_cnt)));
         check("gold_idx", 64'(gidx_a), 64'(g_cnt));
         check("req_busy", 64'(busy_a), 64'd1);
         if (gnt_a) g_cnt++;
      end
      if (done_a === 1'b1) check("pass_rule", 64'(pass_a), 64'((err_a == 0) && !tmo_a));
      if (rst === 1'b0 || (start === 1'b1 && busy_a === 1'b0)) g_cnt = 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic dm_write(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
      dm_addr  = a;
      dm_we    = we;
      dm_wdata = d;
      tick();
      dm_we    = '0;
      dm_addr  = '0;
      dm_wdata = '0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (done_a !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_wait"}, 64'(done_a), 64'd1);
   endtask

   task automatic model(input logic [31:0] mask, output int e, output int fi, output logic [31:0] fg);
      e = 0; fi = 0; fg = '0;
      for (int i = 0; i < NW; i++) begin
         if (((dm_mem[i] ^ gold_mem[i]) & mask) != 0) begin
            if (e == 0) begin
               fi = i;
               fg = dm_mem[i];
            end
            e++;
         end
      end
   endtask

   task automatic check_results(input string name, input int exp_cyc);
      int e, fi;
      logic [31:0] fg;
      model(32'hFFFFFFFF, e, fi, fg);
      check({name, "_a_done"},   64'(done_a), 64'd1);
      check({name, "_a_busy"},   64'(busy_a), 64'd0);
      check({name, "_a_tmo"},    64'(tmo_a),  64'd0);
      check({name, "_a_pass"},   64'(pass_a), 64'(e == 0));
      check({name, "_a_err"},    64'(err_a),  64'(e));
      check({name, "_a_fidx"},   64'(fidx_a), 64'(fi));
      check({name, "_a_fgot"},   64'(fgot_a), 64'(fg));
      check({name, "_a_cyc"},    64'(cyc_a),  64'(exp_cyc));
      check({name, "_a_grants"}, 64'(g_cnt),  64'(NW));
      model(32'hFFFFFFFE, e, fi, fg);
      check({name, "_b_pass"},   64'(pass_b), 64'(e == 0));
      check({name, "_b_err"},    64'(err_b),  64'(e));
      check({name, "_b_fidx"},   64'(fidx_b), 64'(fi));
      check({name, "_b_fgot"},   64'(fgot_b), 64'(fg));
      check({name, "_b_cyc"},    64'(cyc_b),  64'(exp_cyc));
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"},  64'({busy_a, busy_b}), 64'd0);
      check({name, "_done"},  64'({done_a, done_b}), 64'd0);
      check({name, "_pass"},  64'({pass_a, pass_b}), 64'd0);
      check({name, "_tmo"},   64'({tmo_a, tmo_b}),   64'd0);
      check({name, "_req"},   64'({req_a, req_b}),   64'd0);
      check({name, "_addr"},  64'({addr_a, addr_b}), 64'd0);
      check({name, "_gidx"},  64'({gidx_a, gidx_b}), 64'd0);
      check({name, "_err"},   64'({err_a, err_b}),   64'd0);
      check({name, "_fidx"},  64'({fidx_a, fidx_b}), 64'd0);
      check({name, "_fgot"},  64'(fgot_a | fgot_b),  64'd0);
      check({name, "_cyc"},   64'(cyc_a | cyc_b),    64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; start = 1'b0; dm_we = '0; dm_addr = '0; dm_wdata = '0; gnt_mode = 0;
      dm_mem   = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};
      gold_mem = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check_idle("reset");
      tick();
      rst = 1'b1;

      // Golden == DM, DONE at armed cycle 50
      do_arm();
      repeat (50) tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      wait_done("t1");
      check_results("t1", 50);
      check("t1_cyc_lit", 64'(cyc_a), 64'd50);
      check("t1_pass_lit", 64'(pass_a), 64'd1);

      // Single-bit mismatch on word 2, re-armed from FIN
      dm_mem[2]   = 32'h12345678;
      gold_mem[2] = 32'h12345679;
      do_arm();
      repeat (10) tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      wait_done("t2");
      check_results("t2", 10);
      check("t2_err_lit", 64'(err_a), 64'd1);
      check("t2_fidx_lit", 64'(fidx_a), 64'd2);
      check("t2_fgot_lit", 64'(fgot_a), 64'h12345678);
      check("t2_pass_lit", 64'(pass_a), 64'd0);
      check("t2_b_pass_lit", 64'(pass_b), 64'd1);

      // Same data with grants 1,0,0,...: identical results
      gnt_mode = 1;
      do_arm();
      repeat (7) tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      wait_done("t2s");
      check_results("t2s", 7);
      check("t2s_err_lit", 64'(err_a), 64'd1);
      check("t2s_fgot_lit", 64'(fgot_a), 64'h12345678);

      // Several mismatches under stalls
      dm_mem[0]   = 32'hAAAA0000;
      gold_mem[0] = 32'hAAAA0001;
      dm_mem[3]   = 32'h0F0F0F0F;
      gold_mem[3] = 32'hF0F0F0F0;
      do_arm();
      repeat (3) tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      wait_done("t3");
      check_results("t3", 3);
      check("t3_err_lit", 64'(err_a), 64'd3);
      check("t3_b_fidx_lit", 64'(fidx_b), 64'd3);

      // Timeout after exactly MAXC armed cycles; later DONE ignored
      gnt_mode = 0;
      do_arm();
      repeat (MAXC - 1) tick();
      @(negedge clk);
      check("t5_done_early", 64'(done_a), 64'd0);
      tick();
      @(negedge clk);
      check("t5_done", 64'(done_a), 64'd1);
      check("t5_tmo", 64'({tmo_a, tmo_b}), 64'd3);
      check("t5_pass", 64'(pass_a), 64'd0);
      check("t5_busy", 64'(busy_a), 64'd0);
      tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      repeat (3) tick();
      @(negedge clk);
      check("t5_late_done", 64'(done_a), 64'd1);
      check("t5_late_tmo", 64'(tmo_a), 64'd1);
      check("t5_late_busy", 64'(busy_a), 64'd0);

      // DONE in the last allowed cycle beats the timeout
      dm_mem   = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};
      gold_mem = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};
      do_arm();
      repeat (MAXC - 1) tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      wait_done("t7");
      check_results("t7", MAXC - 1);
      check("t7_tmo_lit", 64'(tmo_a), 64'd0);

      // Lane qualification
      do_arm();
      dm_write(16'hFFFC, 4'b1110, 32'h000000FF);
      dm_write(16'hFFFC, 4'b0111, 32'hFF000000);
      dm_write(16'hFFFC, 4'b0001, 32'h000000FE);
      dm_write(16'hFFF8, 4'b0001, 32'h000000FF);
      @(negedge clk);
      check("t6_still_armed", 64'({busy_a, req_a}), 64'b10);
      dm_write(16'hFFFE, 4'b0001, 32'h000000FF);
      wait_done("t6");
      check_results("t6", 4);

      // Reset mid-scan, then a clean rescan
      gnt_mode = 1;
      do_arm();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_idle("t8_rst");
      do_arm();
      repeat (5) tick();
      dm_write(16'hFFFC, 4'hF, 32'h000000FF);
      wait_done("t8");
      check_results("t8", 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
